// File: rtl/demux2_tdm.sv
// demux2_tdm
// ----------
// Two-channel time-division demultiplexer. A serial bit stream carries
// alternating channel 0 and channel 1 words, each WIDTH bits long and sent
// MSB first. A sync marker flags the MSB of each channel 0 word. This block
// tracks frame alignment from that marker and rebuilds both words. Each
// completed word appears on its own registered output, together with a
// one-cycle valid strobe.
//
// Parameters
//   WIDTH       bits per channel word (must be >= 2)
//
// Ports
//   clk         system clock, rising edge active
//   rst_n       asynchronous active-low reset
//   din         serial data bit, MSB first within each word
//   din_valid   qualifies din and sync; when low all state holds
//   sync        marks din as the MSB of a channel 0 word
//   out0        last completed channel 0 word
//   out1        last completed channel 1 word
//   out0_valid  one-cycle pulse when out0 updates
//   out1_valid  one-cycle pulse when out1 updates
//   sel         channel that the next valid bit will be routed to
//   err         one-cycle pulse on a sync seen out of frame position

module demux2_tdm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             sel,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int SW = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [SW-1:0]     sh, sh_next;
  logic [WIDTH-1:0]  out0_next, out1_next;
  logic              out0_valid_next, out1_valid_next;
  logic              sel_next, err_next;

  // A word completes when the current bit is appended to the WIDTH-1 bits
  // already held in the shift register.
  logic [WIDTH-1:0]  word;
  logic [SW-1:0]     sh_shifted;
  logic [SW-1:0]     sh_loaded;
  logic              resync;

  assign word       = {sh, din};
  assign sh_shifted = word[SW-1:0];
  // A new channel 0 word starts with only its MSB in the shift register.
  assign sh_loaded  = SW'(din);

  // A sync is expected only as the first bit of a channel 0 word. A sync
  // anywhere else means that the link has slipped, so the partial word is
  // dropped and framing restarts from this bit.
  assign resync = sync && ((state == CH1) || ((state == CH0) && (cnt != '0)));

  // State register and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      cnt        <= '0;
      sh         <= '0;
      out0       <= '0;
      out1       <= '0;
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
      sel        <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sh         <= sh_next;
      out0       <= out0_next;
      out1       <= out1_next;
      out0_valid <= out0_valid_next;
      out1_valid <= out1_valid_next;
      sel        <= sel_next;
      err        <= err_next;
    end
  end

  // Next-state logic. Everything holds by default, and the strobes and err
  // default low. As a result, a cycle with din_valid low changes only the
  // pulses, which fall back to zero.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    sh_next         = sh;
    out0_next       = out0;
    out1_next       = out1;
    out0_valid_next = 1'b0;
    out1_valid_next = 1'b0;
    err_next        = 1'b0;

    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (sync) begin
            sh_next    = sh_loaded;
            cnt_next   = ONE;
            state_next = CH0;
          end
        end

        CH0, CH1: begin
          if (resync) begin
            err_next   = 1'b1;
            sh_next    = sh_loaded;
            cnt_next   = ONE;
            state_next = CH0;
          end else begin
            sh_next = sh_shifted;
            if (cnt == LAST) begin
              cnt_next = '0;
              if (state == CH0) begin
                out0_next       = word;
                out0_valid_next = 1'b1;
                state_next      = CH1;
              end else begin
                out1_next       = word;
                out1_valid_next = 1'b1;
                state_next      = CH0;
              end
            end else begin
              cnt_next = cnt + ONE;
            end
          end
        end

        default: begin
          state_next = HUNT;
          cnt_next   = '0;
        end
      endcase
    end

    // sel is registered from the next state, so it reflects the channel
    // that the following valid bit will belong to.
    sel_next = (state_next == CH1);
  end

endmodule

// File: tb/tb_demux2_tdm.sv
// tb_demux2_tdm
// -------------
// Directed bench for demux2_tdm (WIDTH=8). A frame-position model tracks
// where each valid bit falls in the 16-bit frame and predicts every output.
// A compare process checks the DUT against that model on each falling edge.
// The stimulus sequence also checks literal expected words and strobes at
// key points.

module tb_demux2_tdm;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] out0, out1;
  logic         out0_valid, out1_valid, sel, err;

  int errors = 0;
  int checks = 0;

  demux2_tdm #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sync       (sync),
    .out0       (out0),
    .out1       (out1),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .sel        (sel),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Model state: the frame position is -1 while hunting, otherwise it is
  // the count of valid bits already received in the current frame (0..15).
  int           m_pos;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_out0, m_out1;
  logic         m_v0, m_v1, m_sel, m_err;

  always @(posedge clk or negedge rst_n) begin : model
    int           p;
    logic [W-1:0] a;
    logic         v0, v1, e;
    logic [W-1:0] o0, o1;
    if (!rst_n) begin
      m_pos  <= -1;
      m_acc  <= '0;
      m_out0 <= '0;
      m_out1 <= '0;
      m_v0   <= 1'b0;
      m_v1   <= 1'b0;
      m_sel  <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      p  = m_pos;
      a  = m_acc;
      o0 = m_out0;
      o1 = m_out1;
      v0 = 1'b0;
      v1 = 1'b0;
      e  = 1'b0;
      if (din_valid) begin
        if (sync && p != 0) begin
          e = (p > 0);
          a = {{(W-1){1'b0}}, din};
          p = 1;
        end else if (p >= 0) begin
          a = {a[W-2:0], din};
          p = p + 1;
          if (p == W) begin
            o0 = a;
            v0 = 1'b1;
          end else if (p == 2 * W) begin
            o1 = a;
            v1 = 1'b1;
            p  = 0;
          end
        end
      end
      m_pos  <= p;
      m_acc  <= a;
      m_out0 <= o0;
      m_out1 <= o1;
      m_v0   <= v0;
      m_v1   <= v1;
      m_err  <= e;
      m_sel  <= (p >= W);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("model_out0", 32'(out0), 32'(m_out0));
    checkOutput("model_out1", 32'(out1), 32'(m_out1));
    checkOutput("model_v0",   32'(out0_valid), 32'(m_v0));
    checkOutput("model_v1",   32'(out1_valid), 32'(m_v1));
    checkOutput("model_sel",  32'(sel), 32'(m_sel));
    checkOutput("model_err",  32'(err), 32'(m_err));
    checkOutput("model_excl", 32'(out0_valid & out1_valid), 32'd0);
  end

  // Drive one cycle. Inputs change at a falling edge, and the task returns at
  // the next falling edge, once the intervening rising edge has sampled them.
  task automatic applyStimulus(input logic b, input logic v, input logic s);
    din       = b;
    din_valid = v;
    sync      = s;
    @(negedge clk);
  endtask

  task automatic sendWord(input logic [W-1:0] w, input logic first_sync);
    for (int i = W - 1; i >= 0; i--)
      applyStimulus(w[i], 1'b1, first_sync && (i == W - 1));
  endtask

  // Idle cycles drive sync and din high so that any leak past din_valid
  // shows up.
  task automatic sendIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1);
  endtask

  task automatic sendFrame(input logic [W-1:0] a, input logic [W-1:0] b);
    sendWord(a, 1'b1);
    checkOutput("frame_v0", 32'(out0_valid), 32'd1);
    checkOutput("frame_out0", 32'(out0), 32'(a));
    checkOutput("frame_sel", 32'(sel), 32'd1);
    sendWord(b, 1'b0);
    checkOutput("frame_v1", 32'(out1_valid), 32'd1);
    checkOutput("frame_out1", 32'(out1), 32'(b));
    checkOutput("frame_sel0", 32'(sel), 32'd0);
  endtask

  initial begin
    logic [W-1:0] wa, wb;
    rst_n = 1'b0;
    din = 1'b0;
    din_valid = 1'b0;
    sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_out0", 32'(out0), 32'd0);
    checkOutput("reset_sel", 32'(sel), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned frame.
    sendFrame(8'hA5, 8'h3C);
    checkOutput("aligned_err", 32'(err), 32'd0);

    // Back-to-back frames.
    sendFrame(8'h12, 8'h34);
    sendFrame(8'hFE, 8'h01);

    // Stalls after bits 4, 8 and 13.
    wa = 8'hA5;
    wb = 8'h3C;
    for (int i = 0; i < 2 * W; i++) begin
      logic b;
      b = (i < W) ? wa[W - 1 - i] : wb[2 * W - 1 - i];
      applyStimulus(b, 1'b1, i == 0);
      if (i == 3 || i == 7 || i == 12) begin
        sendIdle(3);
        if (i == 7) begin
          checkOutput("stall_out0_hold", 32'(out0), 32'hA5);
          checkOutput("stall_sel_hold", 32'(sel), 32'd1);
          checkOutput("stall_v0_low", 32'(out0_valid), 32'd0);
        end
      end
    end
    checkOutput("stall_v1", 32'(out1_valid), 32'd1);
    checkOutput("stall_out1", 32'(out1), 32'h3C);

    // Hunt: pre-sync bits are ignored. This first needs a clean HUNT, so
    // reset between sections.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("hunt_sel", 32'(sel), 32'd0);
    sendFrame(8'h0F, 8'hF0);

    // Misaligned sync on bit 6 of channel 0.
    sendWord(8'hFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("misalign_err", 32'(err), 32'd1);
    checkOutput("misalign_v0", 32'(out0_valid), 32'd0);
    checkOutput("misalign_out0", 32'(out0), 32'hFF);
    wa = 8'hC3;
    for (int i = W - 2; i >= 0; i--) applyStimulus(wa[i], 1'b1, 1'b0);
    checkOutput("misalign_new_out0", 32'(out0), 32'hC3);
    checkOutput("misalign_new_v0", 32'(out0_valid), 32'd1);
    sendWord(8'h5A, 1'b0);
    checkOutput("misalign_new_out1", 32'(out1), 32'h5A);

    // Sync anywhere in channel 1 is also out of position.
    sendWord(8'h11, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("ch1_sync_err", 32'(err), 32'd1);
    checkOutput("ch1_sync_sel", 32'(sel), 32'd0);
    for (int i = 0; i < W - 1; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ch1_sync_out0", 32'(out0), 32'h80);
    sendWord(8'h00, 1'b0);

    // Reset after bit 11.
    sendWord(8'h77, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out0", 32'(out0), 32'd0);
    checkOutput("midrst_out1", 32'(out1), 32'd0);
    checkOutput("midrst_sel", 32'(sel), 32'd0);
    checkOutput("midrst_v", 32'(out0_valid | out1_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    sendFrame(8'h81, 8'h18);
    sendIdle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
